// File: rtl/debug_ram_write_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the debug RAM write arbiter.
// Latency: none (wires only).
// Backpressure: requesters wait for gnt; the RAM side has no backpressure.
// Ports: req/req_we/req_last/req_addr/req_data from requesters; gnt/owner back to them;
//   ram_en/ram_addr/ram_data to RAM port A; forced_release as a status pulse.
interface debug_ram_write_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0]        req_last;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic [1:0]             owner;
  logic                   ram_en;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_data;
  logic                   forced_release;

  // Requester/RAM side of the bundle.
  modport master (
    output req, req_we, req_last, req_addr, req_data,
    input  gnt, owner, ram_en, ram_addr, ram_data, forced_release
  );

  // Arbiter side of the bundle.
  modport slave (
    input  req, req_we, req_last, req_addr, req_data,
    output gnt, owner, ram_en, ram_addr, ram_data, forced_release
  );
endinterface

// File: rtl/debug_ram_write_arbiter.sv
// Round-robin arbiter giving one requester at a time burst-limited ownership of debug RAM port A.
// Latency: gnt 1 cycle after req in IDLE; ram_en/addr/data 1 cycle after the owner's write strobe.
// Backpressure: requesters wait for gnt; non-owner strobes are ignored; bursts are cut at MAX_BURST.
// Ports: clk (port-A clock), rst_n (synchronous, active-low), bus (slave modport):
//   in  req, req_we, req_last, req_addr, req_data (flattened per requester)
//   out gnt (one-hot), owner, ram_en, ram_addr, ram_data, forced_release
module debug_ram_write_arbiter #(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  debug_ram_write_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [1:0]          owner_q, owner_d;
  logic [1:0]          prio_ptr_q, prio_ptr_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic                ram_en_q, ram_en_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                forced_release_q, forced_release_d;

  // Current owner's slice of the request bundle.
  logic                own_req;
  logic                own_we;
  logic                own_last;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_data;

  // Result of the round-robin search.
  logic                pick_vld;
  logic [1:0]          pick_idx;

  // Per-cycle decisions while granted.
  logic                own_wr;
  logic                burst_full;
  logic                release_now;

  // Mux the owner's request lines out of the flattened buses.
  always_comb begin
    own_req  = 1'b0;
    own_we   = 1'b0;
    own_last = 1'b0;
    own_addr = '0;
    own_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (owner_q == 2'(j)) begin
        own_req  = bus.req[j];
        own_we   = bus.req_we[j];
        own_last = bus.req_last[j];
        own_addr = bus.req_addr[j*ADDR_W +: ADDR_W];
        own_data = bus.req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin search starting at prio_ptr. Offsets are walked from the
  // lowest priority to the highest so the last hit, which is the closest
  // requester at or above prio_ptr, is the one that sticks.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (bus.req[j] && (((int'(prio_ptr_q) + k) % NREQ) == j)) begin
          pick_vld = 1'b1;
          pick_idx = 2'(j);
        end
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    owner_d          = owner_q;
    prio_ptr_d       = prio_ptr_q;
    burst_cnt_d      = burst_cnt_q;
    ram_en_d         = 1'b0;
    ram_addr_d       = ram_addr_q;  // held while no write is issued
    ram_data_d       = ram_data_q;
    forced_release_d = 1'b0;
    own_wr           = 1'b0;
    burst_full       = 1'b0;
    release_now      = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_vld) begin
          state_d     = GRANT;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          for (int j = 0; j < NREQ; j++) begin
            gnt_d[j] = (pick_idx == 2'(j));
          end
        end
      end

      GRANT: begin
        // A strobe only counts while the owner still holds req; a strobe in
        // the same cycle req drops is discarded.
        own_wr      = own_req & own_we;
        burst_full  = own_wr && (burst_cnt_q == 8'(MAX_BURST - 1));
        release_now = !own_req || (own_we && own_last) || burst_full;

        if (own_wr) begin
          ram_en_d    = 1'b1;
          ram_addr_d  = own_addr;
          ram_data_d  = own_data;
          burst_cnt_d = burst_cnt_q + 8'd1;
        end

        forced_release_d = burst_full;

        if (release_now) begin
          state_d    = IDLE;
          gnt_d      = '0;
          // The requester after the releasing owner gets first pick next time.
          prio_ptr_d = (owner_q == 2'(NREQ - 1)) ? 2'd0 : owner_q + 2'd1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      gnt_q            <= '0;
      owner_q          <= '0;
      prio_ptr_q       <= '0;
      burst_cnt_q      <= '0;
      ram_en_q         <= 1'b0;
      ram_addr_q       <= '0;
      ram_data_q       <= '0;
      forced_release_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      owner_q          <= owner_d;
      prio_ptr_q       <= prio_ptr_d;
      burst_cnt_q      <= burst_cnt_d;
      ram_en_q         <= ram_en_d;
      ram_addr_q       <= ram_addr_d;
      ram_data_q       <= ram_data_d;
      forced_release_q <= forced_release_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.owner          = owner_q;
  assign bus.ram_en         = ram_en_q;
  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_data       = ram_data_q;
  assign bus.forced_release = forced_release_q;

endmodule

// File: tb/tb_debug_ram_write_arbiter.sv
// Self-checking bench for debug_ram_write_arbiter (NREQ=2, MAX_BURST=4).
// Latency: checks outputs 1 cycle after each applied input vector.
// Backpressure: n/a; the bench plays both requesters.
module tb_debug_ram_write_arbiter;
  localparam int NREQ      = 2;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_ram_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  debug_ram_write_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst_n;
    logic [1:0] req, we, last;
    logic [9:0] a0;
    logic [7:0] d0;
    logic [9:0] a1;
    logic [7:0] d1;
    logic [1:0] e_gnt;
    logic [1:0] e_own;
    logic       e_en;
    logic [9:0] e_addr;
    logic [7:0] e_data;
    logic       e_forced;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] w, input logic [1:0] l,
                     input logic [9:0] a0, input logic [7:0] d0, input logic [9:0] a1, input logic [7:0] d1,
                     input logic [1:0] eg, input logic [1:0] eo, input logic een,
                     input logic [9:0] ea, input logic [7:0] ed, input logic ef);
    vec_t v;
    v.rst_n = r; v.req = rq; v.we = w; v.last = l;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.e_gnt = eg; v.e_own = eo; v.e_en = een; v.e_addr = ea; v.e_data = ed; v.e_forced = ef;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] w, input logic [1:0] l,
                       input logic [9:0] a0, input logic [7:0] d0, input logic [9:0] a1, input logic [7:0] d1);
    rst_n        = r;
    bus.req      = rq;
    bus.req_we   = w;
    bus.req_last = l;
    bus.req_addr = {a1, a0};
    bus.req_data = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int step, input logic [1:0] eg, input logic [1:0] eo,
                            input logic een, input logic [9:0] ea, input logic [7:0] ed, input logic ef,
                            input logic chk_dat);
    chk({tag, "_gnt"}, step, bus.gnt, eg);
    chk({tag, "_owner"}, step, bus.owner, eo);
    chk({tag, "_ram_en"}, step, bus.ram_en, een);
    chk({tag, "_forced"}, step, bus.forced_release, ef);
    if (chk_dat) begin
      chk({tag, "_addr"}, step, bus.ram_addr, ea);
      chk({tag, "_data"}, step, bus.ram_data, ed);
    end
  endtask

  // Reference model: tracks who owns the port and how many writes it has made.
  int         m_cur;
  int         m_writes;
  int         m_pri;
  int         m_owner;
  logic       m_en;
  logic       m_forced;
  logic [9:0] m_addr;
  logic [7:0] m_data;

  task automatic model_step();
    int  o;
    logic done;
    if (!rst_n) begin
      m_cur = -1; m_writes = 0; m_pri = 0; m_owner = 0;
      m_en = 1'b0; m_forced = 1'b0; m_addr = '0; m_data = '0;
    end else if (m_cur < 0) begin
      m_en = 1'b0; m_forced = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_pri + k) % NREQ;
        if (m_cur < 0 && bus.req[c]) begin
          m_cur = c; m_owner = c; m_writes = 0;
        end
      end
    end else begin
      o = m_cur;
      m_en = 1'b0; m_forced = 1'b0;
      done = !bus.req[o];
      if (bus.req_we[o] && bus.req_last[o]) done = 1'b1;
      if (bus.req[o] && bus.req_we[o]) begin
        m_en   = 1'b1;
        m_addr = bus.req_addr[o*ADDR_W +: ADDR_W];
        m_data = bus.req_data[o*DATA_W +: DATA_W];
        m_writes++;
        if (m_writes == MAX_BURST) begin
          m_forced = 1'b1;
          done = 1'b1;
        end
      end
      if (done) begin
        m_cur = -1;
        m_pri = (o + 1) % NREQ;
      end
    end
  endtask

  initial begin
    logic [1:0] rq;
    logic [1:0] w;
    logic [1:0] l;
    logic [1:0] eg;

    // rst req  we   last a0      d0     a1      d1     gnt   own  en  addr    data   forced
    add(0, 2'b11, 2'b11, 2'b00, 10'h001, 8'h01, 10'h002, 8'h02, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0);
    add(0, 2'b11, 2'b11, 2'b00, 10'h001, 8'h01, 10'h002, 8'h02, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0);
    add(0, 2'b11, 2'b11, 2'b00, 10'h001, 8'h01, 10'h002, 8'h02, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0);
    add(1, 2'b11, 2'b11, 2'b00, 10'h001, 8'h01, 10'h002, 8'h02, 2'b01, 2'd0, 0, 10'h000, 8'h00, 0);
    add(1, 2'b00, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0);
    // single burst from requester 1
    add(1, 2'b10, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b10, 2'd1, 0, 10'h000, 8'h00, 0);
    add(1, 2'b10, 2'b10, 2'b00, 10'h000, 8'h00, 10'h005, 8'hA0, 2'b10, 2'd1, 1, 10'h005, 8'hA0, 0);
    add(1, 2'b10, 2'b10, 2'b00, 10'h000, 8'h00, 10'h006, 8'hA1, 2'b10, 2'd1, 1, 10'h006, 8'hA1, 0);
    add(1, 2'b10, 2'b10, 2'b10, 10'h000, 8'h00, 10'h007, 8'hA2, 2'b00, 2'd1, 1, 10'h007, 8'hA2, 0);
    // round robin, non-owner strobe in the first write cycle
    add(1, 2'b11, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b01, 2'd0, 0, 10'h000, 8'h00, 0);
    add(1, 2'b11, 2'b11, 2'b00, 10'h010, 8'h11, 10'h3FF, 8'hFF, 2'b01, 2'd0, 1, 10'h010, 8'h11, 0);
    add(1, 2'b11, 2'b01, 2'b01, 10'h011, 8'h12, 10'h3FF, 8'hFF, 2'b00, 2'd0, 1, 10'h011, 8'h12, 0);
    add(1, 2'b11, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b10, 2'd1, 0, 10'h000, 8'h00, 0);
    add(1, 2'b11, 2'b10, 2'b00, 10'h000, 8'h00, 10'h020, 8'h21, 2'b10, 2'd1, 1, 10'h020, 8'h21, 0);
    add(1, 2'b11, 2'b10, 2'b10, 10'h000, 8'h00, 10'h021, 8'h22, 2'b00, 2'd1, 1, 10'h021, 8'h22, 0);
    add(1, 2'b11, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b01, 2'd0, 0, 10'h000, 8'h00, 0);
    // forced release after 4 writes; requester 1 pending
    add(1, 2'b11, 2'b01, 2'b00, 10'h100, 8'h30, 10'h000, 8'h00, 2'b01, 2'd0, 1, 10'h100, 8'h30, 0);
    add(1, 2'b11, 2'b01, 2'b00, 10'h101, 8'h31, 10'h000, 8'h00, 2'b01, 2'd0, 1, 10'h101, 8'h31, 0);
    add(1, 2'b11, 2'b01, 2'b00, 10'h102, 8'h32, 10'h000, 8'h00, 2'b01, 2'd0, 1, 10'h102, 8'h32, 0);
    add(1, 2'b11, 2'b01, 2'b00, 10'h103, 8'h33, 10'h000, 8'h00, 2'b00, 2'd0, 1, 10'h103, 8'h33, 1);
    add(1, 2'b11, 2'b01, 2'b00, 10'h104, 8'h34, 10'h000, 8'h00, 2'b10, 2'd1, 0, 10'h000, 8'h00, 0);
    add(1, 2'b11, 2'b01, 2'b00, 10'h105, 8'h35, 10'h000, 8'h00, 2'b10, 2'd1, 0, 10'h000, 8'h00, 0);
    // non-owner strobe, then owner drops req together with a strobe
    add(1, 2'b01, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 2'd1, 0, 10'h000, 8'h00, 0);
    add(1, 2'b01, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b01, 2'd0, 0, 10'h000, 8'h00, 0);
    add(1, 2'b11, 2'b10, 2'b00, 10'h000, 8'h00, 10'h2AA, 8'h55, 2'b01, 2'd0, 0, 10'h000, 8'h00, 0);
    add(1, 2'b10, 2'b11, 2'b00, 10'h0F0, 8'h77, 10'h2AB, 8'h56, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0);
    add(1, 2'b00, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].req, vq[i].we, vq[i].last, vq[i].a0, vq[i].d0, vq[i].a1, vq[i].d1);
      tick();
      expect_out("vec", i, vq[i].e_gnt, vq[i].e_own, vq[i].e_en, vq[i].e_addr, vq[i].e_data,
                 vq[i].e_forced, vq[i].e_en | ~vq[i].rst_n);
    end

    // Reset in the cycle of the 2nd strobe; prio_ptr is 1 going in, so a
    // grant to requester 0 afterwards with both requesting shows it was cleared.
    drive(1, 2'b01, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00); tick();
    expect_out("mid_grant", 0, 2'b01, 2'd0, 0, 10'h000, 8'h00, 0, 0);
    drive(1, 2'b01, 2'b01, 2'b00, 10'h055, 8'h66, 10'h000, 8'h00); tick();
    expect_out("mid_wr1", 1, 2'b01, 2'd0, 1, 10'h055, 8'h66, 0, 1);
    drive(0, 2'b01, 2'b01, 2'b00, 10'h056, 8'h67, 10'h000, 8'h00); tick();
    expect_out("mid_rst", 2, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0, 1);
    drive(1, 2'b11, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00); tick();
    expect_out("mid_regrant", 3, 2'b01, 2'd0, 0, 10'h000, 8'h00, 0, 0);
    drive(1, 2'b00, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00); tick();
    expect_out("mid_done", 4, 2'b00, 2'd0, 0, 10'h000, 8'h00, 0, 1);

    // Randomised run against the reference model, starting from reset.
    drive(0, 2'b00, 2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00);
    model_step();
    tick();
    rq = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
        w[i] = ($urandom_range(0, 1) == 1);
        l[i] = ($urandom_range(0, 4) == 0);
      end
      drive(($urandom_range(0, 299) != 0), rq, w, l,
            10'($urandom), 8'($urandom), 10'($urandom), 8'($urandom));
      model_step();
      tick();
      eg = (m_cur < 0) ? 2'b00 : 2'(1 << m_cur);
      expect_out("rnd", n, eg, 2'(m_owner), m_en, m_addr, m_data, m_forced, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/debug_ram_write_arbiter.md
# debug_ram_write_arbiter

Round-robin arbiter that shares the single write port (port A) of the debug character RAM between several writers, such as the rolling test counter and a cellular-automaton engine. Each requester gets exclusive, burst-limited ownership of the port. The arbiter registers the owner's address and data onto port A. It runs entirely in the port-A clock domain; the display side (port B) is untouched.

## Interface

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 16, maximum writes per grant; legal range 1..255.

Ports:
- clk  input  1  port-A clock; the only clock.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  NREQ  per-requester ownership request; level-held until done.
- req_we  input  NREQ  per-requester write strobe; honoured only while granted.
- req_last  input  NREQ  marks the owner's final write; sampled with req_we.
- req_addr  input  NREQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  flattened data; requester i at bits [i*DATA_W +: DATA_W].
- gnt  output  NREQ  one-hot grant, registered.
- owner  output  2  index of the current or last owner.
- ram_en  output  1  to my_ram2 en_a; one-cycle write pulse.
- ram_addr  output  ADDR_W  to my_ram2 addr_a.
- ram_data  output  DATA_W  to my_ram2 data_in_a.
- forced_release  output  1  one-cycle pulse when a grant ends because of MAX_BURST.

## Operation

- FSM states: IDLE and GRANT.
- IDLE:
  - If any req bit is set, pick the first set bit, searching from (prio_ptr) upward modulo NREQ.
  - Load gnt (one-hot) and owner, clear the burst counter, and go to GRANT.
  - Otherwise stay in IDLE with gnt=0.
- GRANT, each cycle with owner o:
  - If req[o]=1 and req_we[o]=1, register ram_addr/ram_data from slice o, set ram_en=1, and increment burst_cnt. burst_cnt is 8 bits wide.
  - Release the grant when any of the following holds:
    - req[o]=0;
    - req_we[o]&req_last[o];
    - a write occurs with burst_cnt==MAX_BURST-1, which is a forced release and pulses forced_release.
  - On release: clear gnt, set prio_ptr=(o+1) mod NREQ, and go to IDLE.
- req_we from non-owners is ignored. req_last without req_we is ignored.
- When req[o] drops and req_we[o] is high in the same cycle, the write is dropped.
- A requester that drops req while not granted simply loses its turn. No state is kept.
- A request already pending is never starved: after at most NREQ-1 other grants it is served.
- ram_addr and ram_data hold their last values while ram_en=0.
- Reset values, all synchronous to clk while rst_n=0:
  - state=IDLE, gnt=0, owner=0, prio_ptr=0;
  - burst_cnt=0, ram_en=0, ram_addr=0, ram_data=0, forced_release=0.
- Reset mid-burst: a write strobed in the reset cycle is not issued, and gnt clears.

## Timing

- Grant latency: req rising in cycle n while in IDLE gives gnt high in cycle n+1.
- Write latency: owner req_we in cycle k gives ram_en=1 with that address and data in cycle k+1. This is one pipeline register, and the RAM captures on the following edge.
- Throughput: one write per cycle during a grant; back-to-back strobes are allowed.
- Release timing: for a release condition in cycle k:
  - gnt=0 in cycle k+1;
  - the final write appears on ram_en in cycle k+1;
  - forced_release is high in cycle k+1;
  - state is IDLE in cycle k+1.
- A new gnt appears in cycle k+2 at earliest, so there is exactly one idle cycle between grants.
- Simultaneous requests in IDLE: the highest-priority requester wins in one cycle, per prio_ptr.

## Test plan

- Reset behaviour: hold rst_n=0 for 3 cycles with req=2'b11 and req_we=2'b11 -> every output reads 0 during reset. After release, gnt=2'b01 appears one cycle later, because prio_ptr=0.
- Single burst: requester 1 alone writes addr 0x005..0x007 with data 0xA0..0xA2 and req_last on the third write -> ram_en is high for 3 consecutive cycles, each one cycle after its strobe. gnt drops together with the third ram_en.
- Round-robin: both requesters hold req continuously, each sending 2 writes with last -> grants alternate 01, 10, 01. There is exactly one idle cycle between grants, and no write from the non-owner appears.
- Forced release: MAX_BURST=4 and requester 0 strobes 6 writes without last -> exactly 4 ram_en pulses. forced_release pulses with the 4th. Requester 1, which was pending, is granted 2 cycles after the 4th strobe.
- Non-owner and dropped writes: requester 1 strobes req_we while requester 0 owns the port, and requester 0 drops req in the same cycle as a req_we -> neither write reaches ram_en. gnt=0 the next cycle.
- Reset mid-burst: assert rst_n=0 in the cycle of requester 0's 2nd strobe -> no 2nd ram_en pulse, gnt=0 and state IDLE. After release, requester 0 is re-granted from prio_ptr=0.
